// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - source encodings and note tables for the sound scheduler
package sound_pkg;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_JUMP = 2'd1;
   localparam logic [1:0] SRC_MS   = 2'd2;
   localparam logic [1:0] SRC_OVER = 2'd3;

   function automatic logic [1:0] note_cnt(input logic [1:0] src);
      case (src)
         SRC_JUMP: return 2'd1;
         SRC_MS:   return 2'd2;
         SRC_OVER: return 2'd3;
         default:  return 2'd0;
      endcase
   endfunction

   // Half-period in clk cycles at the 25.175 MHz pixel clock.
   function automatic logic [15:0] half_period(input logic [1:0] src, input logic [1:0] idx);
      case ({src, idx})
         {SRC_JUMP, 2'd0}: return 16'd15734;
         {SRC_MS,   2'd0}: return 16'd10490;
         {SRC_MS,   2'd1}: return 16'd7867;
         {SRC_OVER, 2'd0}: return 16'd20979;
         {SRC_OVER, 2'd1}: return 16'd27972;
         {SRC_OVER, 2'd2}: return 16'd41958;
         default:          return 16'd0;
      endcase
   endfunction

   function automatic logic [5:0] duration(input logic [1:0] src, input logic [1:0] idx);
      case ({src, idx})
         {SRC_JUMP, 2'd0}: return 6'd6;
         {SRC_MS,   2'd0}: return 6'd4;
         {SRC_MS,   2'd1}: return 6'd4;
         {SRC_OVER, 2'd0}: return 6'd10;
         {SRC_OVER, 2'd1}: return 6'd10;
         {SRC_OVER, 2'd2}: return 6'd20;
         default:          return 6'd0;
      endcase
   endfunction

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - half-period counter producing a square-wave tone
module tone_divider #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_run,
   input  logic [DIV_W-1:0] i_half,
   output logic             o_tone
);

   logic [DIV_W-1:0] r_div_cnt;
   logic             r_tone;
   logic [DIV_W-1:0] w_last;

   // A zero half-period would never match, so it runs as a one-cycle half-period.
   assign w_last = (i_half == '0) ? '0 : i_half - DIV_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_tone    <= 1'b0;
      end else if (i_clear) begin
         r_div_cnt <= '0;
         r_tone    <= 1'b0;
      end else if (i_run) begin
         if (r_div_cnt == w_last) begin
            r_div_cnt <= '0;
            r_tone    <= ~r_tone;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end
      end
   end

   assign o_tone = r_tone;

endmodule

// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - prioritised arbiter and note sequencer for the speaker pin
module sound_scheduler
   import sound_pkg::*;
#(
   parameter int DIV_SHIFT = 0,
   parameter int DIV_W     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_tick,
   input  logic       jump_req,
   input  logic       milestone_req,
   input  logic       over_req,
   input  logic       mute,
   output logic       sound,
   output logic       busy,
   output logic [1:0] active_src
);

   localparam logic IDLE = 1'b0;
   localparam logic PLAY = 1'b1;

   if (DIV_W < 16 && DIV_SHIFT == 0) begin : g_div_w_check
      $error("sound_scheduler: DIV_W below 16 truncates unshifted half-periods");
   end

   logic             r_state;
   logic [1:0]       r_src;
   logic [1:0]       r_note_idx;
   logic [5:0]       r_tick_cnt;
   logic             r_sound;

   logic [1:0]       w_win_src;
   logic             w_accept;
   logic             w_tick;
   logic             w_note_end;
   logic [1:0]       w_next_idx;
   logic             w_has_next;
   logic [15:0]      w_half16;
   logic [DIV_W-1:0] w_half;
   logic             w_tone;

   always_comb begin
      w_win_src = SRC_NONE;
      if (over_req)           w_win_src = SRC_OVER;
      else if (milestone_req) w_win_src = SRC_MS;
      else if (jump_req)      w_win_src = SRC_JUMP;
   end

   // Equal priority restarts the sound; an accepted request swallows a coincident tick.
   assign w_accept   = (w_win_src != SRC_NONE) && (w_win_src >= r_src);
   assign w_tick     = game_tick && (r_state == PLAY) && !w_accept;
   assign w_note_end = w_tick && (r_tick_cnt == 6'd1);
   assign w_next_idx = r_note_idx + 2'd1;
   assign w_has_next = w_next_idx < note_cnt(r_src);
   assign w_half16   = half_period(r_src, r_note_idx) >> DIV_SHIFT;
   assign w_half     = DIV_W'(w_half16);

   tone_divider #(.DIV_W(DIV_W)) u_tone_divider (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_accept || w_note_end),
      .i_run   (r_state == PLAY),
      .i_half  (w_half),
      .o_tone  (w_tone)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_src      <= SRC_NONE;
         r_note_idx <= 2'd0;
         r_tick_cnt <= 6'd0;
         r_sound    <= 1'b0;
      end else begin
         r_sound <= w_tone && !mute && (r_state == PLAY);
         if (w_accept) begin
            r_state    <= PLAY;
            r_src      <= w_win_src;
            r_note_idx <= 2'd0;
            r_tick_cnt <= duration(w_win_src, 2'd0);
         end else if (w_note_end) begin
            if (w_has_next) begin
               r_note_idx <= w_next_idx;
               r_tick_cnt <= duration(r_src, w_next_idx);
            end else begin
               r_state    <= IDLE;
               r_src      <= SRC_NONE;
               r_note_idx <= 2'd0;
               r_tick_cnt <= 6'd0;
            end
         end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt - 6'd1;
         end
      end
   end

   assign sound      = r_sound;
   assign busy       = (r_state == PLAY);
   assign active_src = r_src;

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
Arbitrates the single speaker pin (uio_out[7]) between three sound requesters: jump, score milestone and game over. Sequences each sound as a short list of square-wave notes. Note durations are timed by the 60 Hz game tick; pitch comes from a clk-rate divider. Replaces the single-purpose audio interface in the top level, so that new sound events can share the pin under a defined priority.

Parameters:
DIV_SHIFT, 0, right-shift applied to every note half-period; benches use 8 to shorten pitch periods.
DIV_W, 16, width of the half-period divider counter.

Ports:
clk  in  1  system clock (25.175 MHz pixel clock)
rst  in  1  asynchronous active-high reset
game_tick  in  1  one-cycle 60 Hz pulse
jump_req  in  1  one-cycle request pulse, source 1
milestone_req  in  1  one-cycle request pulse, source 2 (score crosses a multiple of 100)
over_req  in  1  one-cycle request pulse, source 3
mute  in  1  level; forces sound low, sequencing continues
sound  out  1  square wave to speaker
busy  out  1  high while a sound is sequencing
active_src  out  2  0 none, 1 jump, 2 milestone, 3 over

Behaviour:
- Reset: async, active-high. While rst is high or after it releases: state IDLE, sound=0, busy=0, active_src=0, all counters 0. Reset mid-sound aborts the sound immediately; no resume.
- States: IDLE, PLAY. Registers: src[1:0], note_idx[1:0], tick_cnt[5:0], div_cnt[DIV_W-1:0], tone.
- Arbitration:
  - Priority is over > milestone > jump.
  - Simultaneous pulses: the highest-priority one wins; the others are dropped, not queued.
- Accept rule: a request is accepted when its priority is >= src. src=0 in IDLE.
  - Equal priority means restart: retrigger from note 0.
  - Higher priority preempts.
  - Lower priority is dropped.
- Accept at cycle N, effective cycle N+1:
  - state=PLAY, src=winner, note_idx=0, tick_cnt=duration(note 0), div_cnt=0, tone=0.
  - busy and active_src reflect the new sound in cycle N+1.
- Tone generation in PLAY, every clk:
  - If div_cnt == (half(src,note_idx) >> DIV_SHIFT) - 1: tone toggles and div_cnt clears.
  - Otherwise div_cnt increments.
  - First rising edge of tone occurs H cycles after entry, where H is the shifted half-period.
  - A shifted half-period of 0 is treated as 1.
- Duration, on game_tick in PLAY:
  - If tick_cnt==1 and a next note exists: note_idx++, load the new duration, div_cnt=0, tone=0.
  - If tick_cnt==1 and it is the last note: go to IDLE with src=0, tone=0.
  - Otherwise tick_cnt decrements.
  - A note of duration D therefore spans exactly D game_tick pulses after entry.
- Accepted request and game_tick in the same cycle: the request wins and that tick is ignored.
- sound = tone & ~mute & (state==PLAY), registered. Output latency is one clk after tone.
- Note table (half-period in clk cycles, duration in ticks):
  - jump: {15734, 6}
  - milestone: {10490, 4}, {7867, 4}
  - over: {20979, 10}, {27972, 10}, {41958, 20}
- Unused table entries return duration 0 and are never reached (note count per source: 1, 2, 3).
- Widths: durations fit 6 bits; half-periods fit 16 bits. DIV_W < 16 with DIV_SHIFT=0 is illegal and is flagged by a synthesis-time check.

Decomposition:
- Package sound_pkg holds:
  - source encoding constants SRC_NONE/JUMP/MS/OVER;
  - NOTE_CNT per source;
  - the half-period and duration tables as constant functions indexed by (src, note_idx).
- Sub-module tone_divider (div_cnt, tone, load/clear, half input) is natural, so the divider can be reused for a future background beat.
- The arbiter/sequencer FSM stays in sound_scheduler.

Test Plan:
- Reset then jump_req pulse, DIV_SHIFT=8 (H=61):
  - busy=1 and active_src=1 in the next cycle;
  - sound rises 62 clk after accept;
  - period is 122 clk;
  - busy falls on the 6th game_tick; sound=0 afterwards.
- Milestone playing note 1, over_req pulses:
  - active_src=3 next cycle, note_idx=0, H=81;
  - total 40 ticks to IDLE.
- Over playing, then jump_req and milestone_req pulses:
  - both are dropped; active_src stays 3 and note timing is unchanged.
- jump_req, milestone_req and over_req in the same cycle:
  - active_src=3; no pending state remains after IDLE.
- jump_req coincident with game_tick during a jump:
  - the sound restarts and still lasts 6 further ticks.
- mute=1 during an over sequence:
  - sound stays 0 while busy and tick progression are unchanged.
- rst asserted mid-note:
  - sound/busy/active_src go to 0 immediately;
  - after release, no sound until a new request.
